// File: rtl/rijndael_masked_sbox_array.sv
// rijndael_masked_sbox_array: NLANES parallel masked SubBytes lanes with
// valid/ready handshakes on both sides and a programmable S-box settle time.
// Optional build macro RIJNDAEL_SBOX_ZEROIZE_EN clears all data, mask and mode
// registers when a result is handed off, so that dout reads 0 while idle.

// bSbox lane core: takes a masked byte and its input mask, and returns the
// forward or inverse S-box of the underlying byte re-masked with omask.
module rijndael_bsbox (
  input  logic [7:0] din,
  input  logic [7:0] imask,
  input  logic [7:0] omask,
  input  logic       enc,
  output logic [7:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = x;
    for (int k = 0; k < 7; k++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] a;
    a = gf_inv(x);
    return a ^ rotl(a, 1) ^ rotl(a, 2) ^ rotl(a, 3) ^ rotl(a, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    return gf_inv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
  endfunction

  // Mode-selected substitution with the output mask folded in.
  always_comb begin
    if (enc) dout = sbox_fwd(din ^ imask) ^ omask;
    else     dout = sbox_inv(din ^ imask) ^ omask;
  end

endmodule

module rijndael_masked_sbox_array #(
  parameter int NLANES   = 4,
  parameter int SUB_WAIT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  enc,
  input  logic [8*NLANES-1:0]   din,
  input  logic [8*NLANES-1:0]   key,
  input  logic [8*NLANES-1:0]   imask,
  input  logic [8*NLANES-1:0]   omask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NLANES-1:0]   dout,
  output logic                  busy
);

  localparam int W = 8 * NLANES;

  if (SUB_WAIT < 0 || SUB_WAIT > 15) begin : g_bad_sub_wait
    $error("SUB_WAIT must be in 0..15");
  end
  if (NLANES < 1 || NLANES > 16) begin : g_bad_nlanes
    $error("NLANES must be in 1..16");
  end

  localparam logic [3:0] SUB_WAIT_CNT = 4'(SUB_WAIT);

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t         state_reg, state_next;
  logic [3:0]     cnt_reg;
  logic [W-1:0]   data_reg;
  logic [W-1:0]   imask_reg;
  logic [W-1:0]   omask_reg;
  logic           enc_reg;
  logic [W-1:0]   sb_out;
  logic           accept;
  logic           sub_last;
  logic           release_out;

  assign accept      = (state_reg == IDLE) && in_valid;
  assign sub_last    = (state_reg == SUB) && (cnt_reg == 4'd0);
  assign release_out = (state_reg == DONE) && out_ready;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state decode: accept, settle, hand off.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)         state_next = SUB;
      SUB:     if (cnt_reg == 4'd0)  state_next = DONE;
      DONE:    if (out_ready)        state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  // Settle counter: loaded on accept, counts down to zero in SUB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      cnt_reg <= 4'd0;
    else if (accept)                                 cnt_reg <= SUB_WAIT_CNT;
    else if (state_reg == SUB && cnt_reg != 4'd0)    cnt_reg <= cnt_reg - 4'd1;
  end

  // Data, mask and mode capture; S-box result replaces the masked input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      imask_reg <= '0;
      omask_reg <= '0;
      enc_reg   <= 1'b0;
    end else if (accept) begin
      data_reg  <= din ^ key ^ imask;
      imask_reg <= imask;
      omask_reg <= omask;
      enc_reg   <= enc;
    end else if (sub_last) begin
      data_reg  <= sb_out;
`ifdef RIJNDAEL_SBOX_ZEROIZE_EN
    end else if (release_out) begin
      data_reg  <= '0;
      imask_reg <= '0;
      omask_reg <= '0;
      enc_reg   <= 1'b0;
`endif
    end
  end

  // One bSbox per lane; the output mask is stripped from the registered
  // result using the captured mask, never the live port.
  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    rijndael_bsbox u_bsbox (
      .din   (data_reg[8*gi +: 8]),
      .imask (imask_reg[8*gi +: 8]),
      .omask (omask_reg[8*gi +: 8]),
      .enc   (enc_reg),
      .dout  (sb_out[8*gi +: 8])
    );
    assign dout[8*gi +: 8] = data_reg[8*gi +: 8] ^ omask_reg[8*gi +: 8];
  end

endmodule

// File: tb/tb_rijndael_masked_sbox_array.sv
// Directed bench for rijndael_masked_sbox_array: three instances cover
// single-lane zero-wait, four-lane with settle time 3, and reset abort with
// settle time 5. Expected S-box values are FIPS-197 table constants.
module tb_rijndael_masked_sbox_array;

  int checks   = 0;
  int failures = 0;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a: NLANES=1, SUB_WAIT=0
  logic       a_rst_n, a_in_valid, a_in_ready, a_enc, a_out_valid, a_out_ready, a_busy;
  logic [7:0] a_din, a_key, a_imask, a_omask, a_dout;
  // Instance b: NLANES=4, SUB_WAIT=3
  logic        b_rst_n, b_in_valid, b_in_ready, b_enc, b_out_valid, b_out_ready, b_busy;
  logic [31:0] b_din, b_key, b_imask, b_omask, b_dout;
  // Instance c: NLANES=1, SUB_WAIT=5
  logic       c_rst_n, c_in_valid, c_in_ready, c_enc, c_out_valid, c_out_ready, c_busy;
  logic [7:0] c_din, c_key, c_imask, c_omask, c_dout;

`ifdef RIJNDAEL_SBOX_ZEROIZE_EN
  localparam logic [7:0] IDLE_DOUT_EXP = 8'h00;
`else
  localparam logic [7:0] IDLE_DOUT_EXP = 8'hED;
`endif

  rijndael_masked_sbox_array #(.NLANES(1), .SUB_WAIT(0)) u_a (
    .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .enc(a_enc), .din(a_din), .key(a_key), .imask(a_imask), .omask(a_omask),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .dout(a_dout), .busy(a_busy)
  );

  rijndael_masked_sbox_array #(.NLANES(4), .SUB_WAIT(3)) u_b (
    .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .enc(b_enc), .din(b_din), .key(b_key), .imask(b_imask), .omask(b_omask),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .dout(b_dout), .busy(b_busy)
  );

  rijndael_masked_sbox_array #(.NLANES(1), .SUB_WAIT(5)) u_c (
    .clk(clk), .rst_n(c_rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .enc(c_enc), .din(c_din), .key(c_key), .imask(c_imask), .omask(c_omask),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .dout(c_dout), .busy(c_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full handshake on instance a; ports are scrambled after the accept.
  task automatic a_txn(input string tag, input logic e, input logic [7:0] d,
                       input logic [7:0] k, input logic [7:0] im,
                       input logic [7:0] om, input logic [7:0] exp);
    int lat;
    @(negedge clk);
    a_enc = e; a_din = d; a_key = k; a_imask = im; a_omask = om; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_din = 8'($urandom); a_key = 8'($urandom);
    a_imask = 8'($urandom); a_omask = 8'($urandom); a_enc = ~e;
    lat = 0;
    while (!a_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_dout"}, 32'(a_dout), 32'(exp));
    chk({tag, "_inrdy_done"}, 32'(a_in_ready), 32'd0);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    chk({tag, "_ov_idle"}, 32'(a_out_valid), 32'd0);
    $display("txn %s enc=%0d din=%h dout=%h lat=%0d", tag, e, d, exp, lat);
  endtask

  // One full handshake on instance b with immediate out_ready.
  task automatic b_txn(input string tag, input logic [31:0] d, input logic [31:0] k,
                       input logic [31:0] im, input logic [31:0] om,
                       input logic [31:0] exp);
    int lat;
    @(negedge clk);
    b_enc = 1'b1; b_din = d; b_key = k; b_imask = im; b_omask = om; b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    b_omask = $urandom;
    lat = 0;
    while (!b_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_dout"}, b_dout, exp);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    $display("txn %s imask=%h omask=%h dout=%h lat=%0d", tag, im, om, b_dout, lat);
  endtask

  initial begin
    int lat;
    int ov_seen;
    logic [31:0] bp_exp;

    a_rst_n = 1'b0; a_in_valid = 1'b0; a_enc = 1'b0; a_out_ready = 1'b0;
    a_din = '0; a_key = '0; a_imask = '0; a_omask = '0;
    b_rst_n = 1'b0; b_in_valid = 1'b0; b_enc = 1'b0; b_out_ready = 1'b0;
    b_din = '0; b_key = '0; b_imask = '0; b_omask = '0;
    c_rst_n = 1'b0; c_in_valid = 1'b0; c_enc = 1'b0; c_out_valid_unused();
    c_din = '0; c_key = '0; c_imask = '0; c_omask = '0;

    repeat (2) @(negedge clk);

    // Reset state
    chk("a_rst_ov", 32'(a_out_valid), 32'd0);
    chk("a_rst_busy", 32'(a_busy), 32'd0);
    chk("a_rst_dout", 32'(a_dout), 32'd0);
    chk("a_rst_inrdy", 32'(a_in_ready), 32'd1);
    chk("b_rst_dout", b_dout, 32'd0);
    chk("b_rst_busy", 32'(b_busy), 32'd0);
    a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;

    // Single lane, forward and inverse
    a_txn("a_fwd00", 1'b1, 8'h00, 8'h00, 8'h5A, 8'hC3, 8'h63);
    a_txn("a_inv63", 1'b0, 8'h63, 8'h00, 8'h77, 8'h19, 8'h00);
    a_txn("a_invED", 1'b0, 8'hED, 8'h00, 8'h77, 8'h19, 8'h53);
    a_txn("a_fwd53", 1'b1, 8'h53, 8'h00, 8'h3E, 8'hA1, 8'hED);
    chk("a_idle_dout", 32'(a_dout), 32'(IDLE_DOUT_EXP));
    // Key folded in: 0x42 ^ 0x11 = 0x53 -> 0xED
    a_txn("a_fwdkey", 1'b1, 8'h42, 8'h11, 8'hF0, 8'h0F, 8'hED);

    // Four lanes, result independent of random masks
    for (int n = 0; n < 1000; n++) begin
      b_txn("b_mask", 32'h0053_11FF, 32'h0, $urandom, $urandom, 32'h63ED_8216);
    end

    // Backpressure: dout stable, in_valid during DONE ignored
    bp_exp = 32'h6363_63ED;
    @(negedge clk);
    b_enc = 1'b1; b_din = 32'h0; b_key = 32'h0000_0053;
    b_imask = $urandom; b_omask = $urandom; b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b_bp_lat", 32'(lat), 32'd4);
    chk("b_bp_dout0", b_dout, bp_exp);
    b_in_valid = 1'b1; b_din = 32'hFFFF_FFFF; b_omask = $urandom;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("b_bp_dout_hold", b_dout, bp_exp);
      chk("b_bp_ov_hold", 32'(b_out_valid), 32'd1);
      chk("b_bp_inrdy_hold", 32'(b_in_ready), 32'd0);
    end
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    b_in_valid = 1'b0;
    chk("b_rel_busy", 32'(b_busy), 32'd0);
    chk("b_rel_ov", 32'(b_out_valid), 32'd0);
    chk("b_rel_inrdy", 32'(b_in_ready), 32'd1);
    $display("txn b_bp dout=%h lat=%0d", bp_exp, lat);

    // Reset abort during SUB on instance c
    @(negedge clk);
    c_enc = 1'b1; c_din = 8'h11; c_key = 8'h00; c_imask = 8'hA5; c_omask = 8'h3C;
    c_in_valid = 1'b1;
    @(negedge clk);
    c_in_valid = 1'b0;
    @(negedge clk);
    chk("c_sub_busy", 32'(c_busy), 32'd1);
    c_rst_n = 1'b0;
    #1;
    chk("c_abort_ov", 32'(c_out_valid), 32'd0);
    chk("c_abort_busy", 32'(c_busy), 32'd0);
    chk("c_abort_dout", 32'(c_dout), 32'd0);
    @(negedge clk);
    c_rst_n = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (c_out_valid) ov_seen++;
    end
    chk("c_abort_no_ov", 32'(ov_seen), 32'd0);
    $display("txn c_abort din=11 aborted");

    // Later transaction on c completes normally
    @(negedge clk);
    c_enc = 1'b1; c_din = 8'hFF; c_key = 8'h00; c_imask = 8'h6B; c_omask = 8'hD2;
    c_in_valid = 1'b1;
    @(negedge clk);
    c_in_valid = 1'b0;
    lat = 0;
    while (!c_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("c_post_lat", 32'(lat), 32'd6);
    chk("c_post_dout", 32'(c_dout), 32'h16);
    c_out_ready = 1'b1;
    @(negedge clk);
    c_out_ready = 1'b0;
    chk("c_post_idle", 32'(c_busy), 32'd0);
    $display("txn c_post din=ff dout=%h lat=%0d", c_dout, lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic c_out_valid_unused();
    c_out_ready = 1'b0;
  endtask

endmodule
